ysyx_23060184_exu_mdu: RTL and testbench



---
 rtl/ysyx_23060184_exu_mdu.sv | 174 +++++++++++++++++
 tb/tb_ysyx_23060184_exu_mdu.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_exu_mdu.sv
// Iterative RV-M mul/div: XLEN+1 cycles accept-to-valid, 1 cycle for divide special cases; holds DONE until out_ready.
// Optional YSYX_23060184_MDU_EARLY_OUT_EN: multiplies retire once the remaining multiplier bits are zero.
module ysyx_23060184_exu_mdu #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic               r_neg;
  logic [2*XLEN-1:0]  r_acc;
  logic [2*XLEN-1:0]  r_x;
  logic [XLEN-1:0]    r_y;
  logic [XLEN-1:0]    r_result;
  logic [TAG_W-1:0]   r_tag;

  logic               w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic               w_b_zero, w_ovf, w_special, w_last;
  logic [XLEN-1:0]    w_a_mag, w_b_mag, w_spec_res;

  assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
  assign w_is_div = in_op[2];
  assign w_a_sgn  = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign w_b_sgn  = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);
  assign w_a_neg  = w_a_sgn && in_a[XLEN-1];
  assign w_b_neg  = w_b_sgn && in_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -in_a : in_a;
  assign w_b_mag  = w_b_neg ? -in_b : in_b;
  assign w_b_zero = (in_b == '0);
  assign w_ovf    = ((in_op == 3'd4) || (in_op == 3'd6)) && (in_a == MOST_NEG) && (&in_b);

  // in_op[1] distinguishes REM/REMU from DIV/DIVU among divides
  always_comb begin
    w_special  = 1'b0;
    w_spec_res = '0;
    if (w_is_div) begin
      if (w_b_zero) begin
        w_special  = 1'b1;
        w_spec_res = in_op[1] ? in_a : '1;
      end else if (w_ovf) begin
        w_special  = 1'b1;
        w_spec_res = in_op[1] ? '0 : in_a;
      end
    end
`ifdef YSYX_23060184_MDU_EARLY_OUT_EN
    else if ((in_a == '0) || w_b_zero) begin
      w_special  = 1'b1;
      w_spec_res = '0;
    end
`endif
  end

  // Multiply step: multiplicand shifts left, multiplier shifts right
  logic [2*XLEN-1:0] w_mul_acc_nxt, w_prod;
  logic [XLEN-1:0]   w_mul_y_nxt, w_mul_res;
  assign w_mul_acc_nxt = r_y[0] ? (r_acc + r_x) : r_acc;
  assign w_mul_y_nxt   = r_y >> 1;
  assign w_prod        = r_neg ? -w_mul_acc_nxt : w_mul_acc_nxt;
  assign w_mul_res     = (r_op == 3'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Restoring divide step: r_y holds dividend bits shifting out / quotient bits shifting in
  logic [XLEN:0]   w_div_sh, w_div_diff;
  logic            w_div_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_div_raw, w_div_res, w_res;
  assign w_div_sh   = {r_acc[XLEN-1:0], r_y[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_x[XLEN-1:0]};
  assign w_div_ge   = !w_div_diff[XLEN];
  assign w_rem_nxt  = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
  assign w_quo_nxt  = {r_y[XLEN-2:0], w_div_ge};
  assign w_div_raw  = r_op[1] ? w_rem_nxt : w_quo_nxt;
  assign w_div_res  = r_neg ? -w_div_raw : w_div_raw;
  assign w_res      = r_op[2] ? w_div_res : w_mul_res;

`ifdef YSYX_23060184_MDU_EARLY_OUT_EN
  assign w_last = (r_cnt == CNT_W'(1)) || (!r_op[2] && (w_mul_y_nxt == '0));
`else
  assign w_last = (r_cnt == CNT_W'(1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_special ? S_DONE : S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_tag    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op  <= in_op;
        r_tag <= in_tag;
        r_acc <= '0;
        r_neg <= (w_is_div && in_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        if (w_is_div) begin
          r_x <= {{XLEN{1'b0}}, w_b_mag};
          r_y <= w_a_mag;
        end else begin
          r_x <= {{XLEN{1'b0}}, w_a_mag};
          r_y <= w_b_mag;
        end
        if (w_special) begin
          r_result <= w_spec_res;
          r_cnt    <= '0;
        end else begin
          r_cnt <= CNT_W'(XLEN);
        end
      end else if ((r_state == S_BUSY) && !flush) begin
        r_cnt <= w_last ? '0 : (r_cnt - CNT_W'(1));
        if (r_op[2]) begin
          r_acc <= {{XLEN{1'b0}}, w_rem_nxt};
          r_y   <= w_quo_nxt;
        end else begin
          r_acc <= w_mul_acc_nxt;
          r_x   <= r_x << 1;
          r_y   <= w_mul_y_nxt;
        end
        if (w_last) r_result <= w_res;
      end
    end
  end

  assign out_result = r_result;
  assign out_tag    = r_tag;

endmodule

// File: tb/tb_ysyx_23060184_exu_mdu.sv
// Scoreboard bench for ysyx_23060184_exu_mdu: driver pushes expectations, negedge monitor pops and compares.
module tb_ysyx_23060184_exu_mdu;
  localparam int XLEN = 32, TAG_W = 5, CNT_W = 6;

  logic             clk = 1'b0, rstn = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic             in_ready, out_valid, busy;
  logic [2:0]       in_op = '0;
  logic [XLEN-1:0]  in_a = '0, in_b = '0, out_result;
  logic [TAG_W-1:0] in_tag = '0, out_tag;

  ysyx_23060184_exu_mdu #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;

  localparam int LAT_FULL = XLEN + 1;
  localparam int LAT_SPEC = 1;
`ifdef YSYX_23060184_MDU_EARLY_OUT_EN
  localparam int LAT_MUL_5X3 = 3;
`else
  localparam int LAT_MUL_5X3 = LAT_FULL;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: latency from acceptance to out_valid rise, result/tag on every valid cycle
  initial begin : monitor
    int   cyc;
    int   acc_cyc;
    logic prev_v;
    cyc = 0; acc_cyc = 0; prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn && in_valid && in_ready && !flush) acc_cyc = cyc;
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) check("spurious out_valid", {63'b0, out_valid}, 64'd0);
        else check($sformatf("latency tag%0d", sb[0].tag), 64'(cyc - acc_cyc), 64'(sb[0].lat));
      end
      if (out_valid && sb.size() != 0) begin
        check($sformatf("result tag%0d", sb[0].tag), {32'b0, out_result}, {32'b0, sb[0].res});
        check($sformatf("out_tag tag%0d", sb[0].tag), {59'b0, out_tag}, {59'b0, sb[0].tag});
        if (!out_ready) check("in_ready held in DONE", {63'b0, in_ready}, 64'd0);
        else void'(sb.pop_front());
      end
      prev_v = out_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one request for a single accepting edge; push=0 for ops that will be killed
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res, input int lat,
                       input bit push);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("in_ready wait timeout", {63'b0, in_ready}, 64'd1);
    e.res = res; e.tag = tag; e.lat = lat;
    if (push) sb.push_back(e);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      check("drain timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] res, input int lat);
    issue(op, a, b, tag, res, lat, 1'b1);
    drain();
  endtask

  task automatic check_idle(input string name);
    check({name, " in_ready"}, {63'b0, in_ready}, 64'd1);
    check({name, " out_valid"}, {63'b0, out_valid}, 64'd0);
    check({name, " busy"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin : driver
    int n;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset out_result", {32'b0, out_result}, 64'd0);
    check("reset out_tag", {59'b0, out_tag}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Multiplies
    run(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LAT_FULL);
    run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, LAT_FULL);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, LAT_FULL);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, LAT_FULL);
    run(3'd0, 32'd5,        32'd3,         5'd9,  32'd15,        LAT_MUL_5X3);
    // Divides
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, LAT_FULL);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, LAT_FULL);
    run(3'd5, 32'd100,      32'd7, 5'd12, 32'd14,        LAT_FULL);
    run(3'd7, 32'd100,      32'd7, 5'd13, 32'd2,         LAT_FULL);
    // Divide special cases take the one-cycle path
    run(3'd4, 32'd1234,      32'd0,         5'd14, 32'hFFFF_FFFF, LAT_SPEC);
    run(3'd7, 32'd9,         32'd0,         5'd15, 32'd9,         LAT_SPEC);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, LAT_SPEC);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         LAT_SPEC);

    // Back-pressure: result held for 10 cycles, then released
    out_ready = 1'b0;
    issue(3'd7, 32'd100, 32'd7, 5'd18, 32'd2, LAT_FULL, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("hold reached DONE", {63'b0, out_valid}, 64'd1);
    repeat (10) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_idle("after release");
    drain();

    // Flush in BUSY cycle 10; a request alongside flush must not be taken
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd19, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("busy before flush", {63'b0, busy}, 64'd1);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_idle("after busy flush");
    in_op = 3'd5; in_a = 32'd9; in_b = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_idle("flush blocks accept");
    repeat (40) @(posedge clk);
    #1;
    run(3'd5, 32'd9, 32'd3, 5'd20, 32'd3, LAT_FULL);

    // Asynchronous reset mid-BUSY
    issue(3'd5, 32'd100, 32'd7, 5'd21, 32'd0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_idle("async reset");
    check("async reset out_result", {32'b0, out_result}, 64'd0);
    check("async reset out_tag", {59'b0, out_tag}, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    run(3'd5, 32'd9, 32'd3, 5'd22, 32'd3, LAT_FULL);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
